// File: rtl/addr_counter_pkg.sv
// Shared types for the address-decoded counter bank: opcodes, sweep FSM states, defaults.
package addr_counter_pkg;

    localparam int DEF_WIDTH  = 10;
    localparam int DEF_ADDR_W = 9;

    // Codes 6 and 7 are deliberately absent; they decode as illegal.
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_INC  = 3'd1,
        OP_DEC  = 3'd2,
        OP_LOAD = 3'd3,
        OP_CLR  = 3'd4,
        OP_READ = 3'd5
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/addr_counter_bank_ctr_update.sv
// Combinational next-value and overflow decode for a single counter channel.
// Wraps or clamps at 0 / all-ones depending on SATURATE; illegal opcodes leave the count untouched.
module ctr_update
    import addr_counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] count_o,
    output logic             ovf_set_o,
    output logic             ovf_clr_o,
    output logic             err_o
);

    always_comb begin
        count_o   = count_i;
        ovf_set_o = 1'b0;
        ovf_clr_o = 1'b0;
        err_o     = 1'b0;
        case (op_i)
            OP_NOP, OP_READ: ;
            OP_INC: begin
                if (&count_i) begin
                    ovf_set_o = 1'b1;
                    count_o   = SATURATE ? count_i : '0;
                end else begin
                    count_o = count_i + WIDTH'(1);
                end
            end
            OP_DEC: begin
                if (count_i == '0) begin
                    ovf_set_o = 1'b1;
                    count_o   = SATURATE ? '0 : '1;
                end else begin
                    count_o = count_i - WIDTH'(1);
                end
            end
            OP_LOAD: count_o = data_i;
            OP_CLR: begin
                count_o   = '0;
                ovf_clr_o = 1'b1;
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/addr_counter_bank.sv
// Bank of CHANNELS counters behind a valid/ready command port with a one-deep registered response.
// A soft clear sweeps one channel per cycle and blocks commands until it finishes.
module addr_counter_bank
    import addr_counter_pkg::*;
#(
    parameter int                WIDTH     = DEF_WIDTH,
    parameter int                CHANNELS  = 4,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(9'h10F),
    parameter bit                SATURATE  = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_W-1:0]           cmd_addr,
    input  logic [2:0]                  cmd_op,
    input  logic [$clog2(CHANNELS)-1:0] cmd_ch,
    input  logic [WIDTH-1:0]            cmd_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WIDTH-1:0]            rsp_data,
    output logic                        rsp_err,
    input  logic                        soft_clr,
    output logic                        busy,
    output logic [CHANNELS-1:0]         ovf
);

    localparam int              CH_W    = $clog2(CHANNELS);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    state_e              state_q;
    logic [CH_W-1:0]     idx_q;
    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic             accept, hit;
    logic [WIDTH-1:0] upd_count;
    logic             upd_set, upd_clr, upd_err;

    // soft_clr wins over a same-cycle command, which stays pending.
    assign busy      = (state_q == ST_SWEEP);
    assign cmd_ready = rst_n && !busy && !soft_clr && (!rsp_valid_q || rsp_ready);
    assign accept    = cmd_valid && cmd_ready;
    assign hit       = accept && (cmd_addr == BASE_ADDR);

    ctr_update #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_ctr_update (
        .op_i      (cmd_op),
        .count_i   (cnt_q[cmd_ch]),
        .data_i    (cmd_data),
        .count_o   (upd_count),
        .ovf_set_o (upd_set),
        .ovf_clr_o (upd_clr),
        .err_o     (upd_err)
    );

    always_comb begin
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (busy) begin
            cnt_d[idx_q] = '0;
            ovf_d[idx_q] = 1'b0;
        end
        if (hit) begin
            cnt_d[cmd_ch] = upd_count;
            if (upd_set) ovf_d[cmd_ch] = 1'b1;
            if (upd_clr) ovf_d[cmd_ch] = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = upd_err;
            rsp_data_d  = upd_err ? '0 : upd_count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (soft_clr) begin
                        state_q <= ST_SWEEP;
                        idx_q   <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (idx_q == LAST_CH) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + CH_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
            ovf_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_addr_counter_bank.sv
// Drives a wrapping and a saturating bank with identical stimulus and checks both against a reference model.
module tb_addr_counter_bank;

    localparam logic [8:0] BASE = 9'h10F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [8:0] cmd_addr = '0;
    logic [2:0] cmd_op = '0;
    logic [1:0] cmd_ch = '0;
    logic [9:0] cmd_data = '0;
    logic       rsp_ready = 1'b1;
    logic       soft_clr = 1'b0;

    logic       rdy_w, vld_w, err_w, busy_w;
    logic       rdy_s, vld_s, err_s, busy_s;
    logic [9:0] dat_w, dat_s;
    logic [3:0] ovf_w, ovf_s;

    int n_checks = 0;
    int n_fail   = 0;

    int         mw [4];
    int         ms [4];
    logic [3:0] ow, os;
    int         ew, es;
    bit         eerr;

    always #5 clk = ~clk;

    addr_counter_bank #(.WIDTH(10), .CHANNELS(4), .ADDR_W(9), .BASE_ADDR(BASE), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy_w), .cmd_addr(cmd_addr),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .rsp_valid(vld_w), .rsp_ready(rsp_ready),
        .rsp_data(dat_w), .rsp_err(err_w), .soft_clr(soft_clr), .busy(busy_w), .ovf(ovf_w));

    addr_counter_bank #(.WIDTH(10), .CHANNELS(4), .ADDR_W(9), .BASE_ADDR(BASE), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy_s), .cmd_addr(cmd_addr),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .rsp_valid(vld_s), .rsp_ready(rsp_ready),
        .rsp_data(dat_s), .rsp_err(err_s), .soft_clr(soft_clr), .busy(busy_s), .ovf(ovf_s));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mw[i] = 0;
            ms[i] = 0;
        end
        ow = '0;
        os = '0;
    endtask

    // Reference behaviour: wrap mode is arithmetic modulo 1024, saturate mode clamps to [0, 1023].
    task automatic model_apply(input logic [2:0] op, input int ch, input int d);
        eerr = 1'b0;
        case (op)
            3'd1: begin
                if (mw[ch] == 1023) ow[ch] = 1'b1;
                mw[ch] = (mw[ch] + 1) % 1024;
                if (ms[ch] == 1023) os[ch] = 1'b1;
                else ms[ch] = ms[ch] + 1;
            end
            3'd2: begin
                if (mw[ch] == 0) ow[ch] = 1'b1;
                mw[ch] = (mw[ch] + 1023) % 1024;
                if (ms[ch] == 0) os[ch] = 1'b1;
                else ms[ch] = ms[ch] - 1;
            end
            3'd3: begin
                mw[ch] = d;
                ms[ch] = d;
            end
            3'd4: begin
                mw[ch] = 0;
                ms[ch] = 0;
                ow[ch] = 1'b0;
                os[ch] = 1'b0;
            end
            3'd0, 3'd5: ;
            default: eerr = 1'b1;
        endcase
        ew = eerr ? 0 : mw[ch];
        es = eerr ? 0 : ms[ch];
    endtask

    task automatic check_rsp(input string tag);
        chk({tag, "_vld_w"}, vld_w, 1);
        chk({tag, "_vld_s"}, vld_s, 1);
        chk({tag, "_dat_w"}, dat_w, ew);
        chk({tag, "_dat_s"}, dat_s, es);
        chk({tag, "_err_w"}, err_w, eerr);
        chk({tag, "_err_s"}, err_s, eerr);
        chk({tag, "_ovf_w"}, ovf_w, ow);
        chk({tag, "_ovf_s"}, ovf_s, os);
    endtask

    // Issues one command and checks the response one cycle after acceptance; returns at a falling edge.
    task automatic send(input string tag, input logic [8:0] a, input logic [2:0] op, input int ch, input int d);
        int n;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_op    = op;
        cmd_ch    = 2'(ch);
        cmd_data  = 10'(d);
        @(negedge clk);
        n = 0;
        while (!(rdy_w && rdy_s) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, {rdy_w, rdy_s}, 2'b11);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        if (a == BASE) begin
            model_apply(op, ch, d);
            check_rsp(tag);
        end else begin
            chk({tag, "_miss_vld"}, {vld_w, vld_s}, 2'b00);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        model_reset();

        // Reset values
        @(negedge clk);
        chk("rst_ready", {rdy_w, rdy_s}, 2'b00);
        chk("rst_vld", {vld_w, vld_s}, 2'b00);
        chk("rst_dat", {dat_w, dat_s}, 0);
        chk("rst_err", {err_w, err_s}, 2'b00);
        chk("rst_busy", {busy_w, busy_s}, 2'b00);
        chk("rst_ovf", {ovf_w, ovf_s}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Wrap and clamp at the top
        send("load1", BASE, 3'd3, 1, 10'h3FE);
        send("inc1a", BASE, 3'd1, 1, 0);
        send("inc1b", BASE, 3'd1, 1, 0);

        // Underflow at zero, then CLR drops the flag
        send("dec0", BASE, 3'd2, 0, 0);
        send("clr0", BASE, 3'd4, 0, 0);

        // Foreign address consumed silently; illegal opcode flagged
        send("miss", BASE + 9'd1, 3'd1, 1, 0);
        send("rd1", BASE, 3'd5, 1, 0);
        send("ill7", BASE, 3'd7, 2, 10'h155);
        send("ill6", BASE, 3'd6, 3, 10'h2AA);

        // Backpressure: response held while rsp_ready is low
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        send("bp_inc", BASE, 3'd1, 2, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", {rdy_w, rdy_s}, 2'b00);
            chk("bp_vld", {vld_w, vld_s}, 2'b11);
            chk("bp_dat_w", dat_w, ew);
            chk("bp_dat_s", dat_s, es);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = BASE;
        cmd_op    = 3'd5;
        cmd_ch    = 2'd2;
        #1;
        chk("bp_release_ready", {rdy_w, rdy_s}, 2'b11);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        model_apply(3'd5, 2, 0);
        @(negedge clk);
        check_rsp("bp_rd");

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [8:0] a;
            a = ($urandom_range(0, 7) == 0) ? BASE ^ 9'(1 << $urandom_range(0, 8)) : BASE;
            send("rand", a, 3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 1023));
        end

        // Soft clear with a command pending in the same cycle
        for (int c = 0; c < 4; c++) send("ld5", BASE, 3'd3, c, 5);
        send("ovf3", BASE, 3'd3, 3, 10'h3FF);
        send("ovf3i", BASE, 3'd1, 3, 0);
        @(posedge clk);
        #1;
        soft_clr  = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = BASE;
        cmd_op    = 3'd5;
        cmd_ch    = 2'd1;
        @(negedge clk);
        chk("sc_prio_ready", {rdy_w, rdy_s}, 2'b00);
        @(posedge clk);
        #1 soft_clr = 1'b0;
        model_reset();
        bc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy_w) break;
            bc++;
            chk("sc_busy_s", busy_s, 1);
            chk("sc_ready_lo", {rdy_w, rdy_s}, 2'b00);
        end
        chk("sc_busy_cycles", bc, 4);
        chk("sc_ready_after", {rdy_w, rdy_s}, 2'b11);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        model_apply(3'd5, 1, 0);
        @(negedge clk);
        check_rsp("sc_pending");
        for (int c = 0; c < 4; c++) send("sc_rd", BASE, 3'd5, c, 0);

        // Reset in the middle of a sweep
        send("mr_ld", BASE, 3'd3, 3, 10'h3FF);
        send("mr_inc", BASE, 3'd1, 3, 0);
        @(posedge clk);
        #1 soft_clr = 1'b1;
        @(posedge clk);
        #1 soft_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_busy", {busy_w, busy_s}, 2'b11);
        chk("mr_ovf3", {ovf_w[3], ovf_s[3]}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("mr_busy0", {busy_w, busy_s}, 2'b00);
        chk("mr_ready0", {rdy_w, rdy_s}, 2'b00);
        chk("mr_vld0", {vld_w, vld_s}, 2'b00);
        chk("mr_ovf0", {ovf_w, ovf_s}, 0);
        chk("mr_dat0", {dat_w, dat_s, err_w, err_s}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        send("mr_rd3", BASE, 3'd5, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
